// File: rtl/fc_pkg.sv
// Shared definitions for the ternary fully-connected layer: weight codes,
// FSM states, internal accumulator sizing and the output clamp.
package fc_pkg;

  localparam logic [1:0] TW_POS  = 2'b01;
  localparam logic [1:0] TW_NEG  = 2'b11;
  localparam logic [1:0] TW_ZERO = 2'b00;

  typedef enum logic {ST_ACC, ST_OUT} state_e;

  // Accumulator width large enough that N_IN full-scale beats cannot overflow.
  function automatic int acc_int_w(input int a_w, input int n_in);
    return a_w + $clog2(n_in) + 1;
  endfunction

  // Clamp to ACC_W signed range; without bypass the lower bound is 0 (ReLU).
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int acc_w,
                                                  input logic bypass);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = bypass ? -(64'sd1 <<< (acc_w - 1)) : 64'sd0;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/fc_ternary_neuron.sv
// One neuron: ternary add/sub/skip accumulator with load-on-first-beat and
// a saturated, optionally rectified result register captured on the last beat.
module fc_ternary_neuron
  import fc_pkg::*;
#(
  parameter int A_W   = 9,
  parameter int ACC_W = 16,
  parameter int AI    = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_beat,
  input  logic                    i_first,
  input  logic                    i_last,
  input  logic                    i_bypass,
  input  logic [1:0]              i_wt,
  input  logic signed [A_W-1:0]   i_act,
  output logic signed [ACC_W-1:0] o_res
);

  logic signed [AI-1:0]    w_act_x;
  logic signed [AI-1:0]    w_term;
  logic signed [AI-1:0]    w_sum;
  logic signed [AI-1:0]    r_acc;
  logic signed [ACC_W-1:0] r_res;

  assign w_act_x = AI'(i_act);

  // Map the ternary code onto +a / -a / 0; the reserved code 10 falls to 0.
  always_comb begin
    w_term = '0;
    case (i_wt)
      TW_POS:  w_term = w_act_x;
      TW_NEG:  w_term = -w_act_x;
      default: w_term = '0;
    endcase
  end

  // First beat of a frame overwrites, so no explicit clear between frames.
  assign w_sum = i_first ? w_term : r_acc + w_term;

  // Accumulate each accepted beat; register the clamped result on the last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_res <= '0;
    end else if (i_beat) begin
      r_acc <= w_sum;
      if (i_last)
        r_res <= ACC_W'(sat_relu(64'(w_sum), ACC_W, i_bypass));
    end
  end

  assign o_res = r_res;

endmodule

// File: rtl/fc_ternary_layer.sv
// Ternary-weight fully-connected layer: streams N_IN activations, updates
// N_OUT neurons in parallel, then holds the result vector until accepted.
module fc_ternary_layer
  import fc_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_OUT = 10,
  parameter int A_W   = 9,
  parameter int ACC_W = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [A_W-1:0]                 in_data,
  input  logic                           relu_bypass,
  input  logic                           wt_we,
  input  logic [$clog2(N_OUT*N_IN)-1:0]  wt_addr,
  input  logic [1:0]                     wt_data,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_OUT*ACC_W-1:0]         out_data
);

  localparam int NW = N_OUT * N_IN;
  localparam int AW = $clog2(NW);
  localparam int CW = $clog2(N_IN);
  localparam int AI = acc_int_w(A_W, N_IN);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_IN - 1);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_out_valid;
  logic [1:0]    r_wt [NW];

  logic w_accept;
  logic w_first;
  logic w_last;

  assign in_ready  = (r_state == ST_ACC);
  assign busy      = (r_cnt != '0) || (r_state == ST_OUT);
  assign out_valid = r_out_valid;
  assign w_accept  = in_valid && in_ready;
  assign w_first   = (r_cnt == '0);
  assign w_last    = (r_cnt == CNT_LAST);

  // Frame sequencing: count beats in ACC, hold the result in OUT until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_ACC;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            if (w_last) begin
              r_cnt       <= '0;
              r_state     <= ST_OUT;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_state     <= ST_ACC;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_ACC;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Weight store; writes are ignored mid-frame so a frame sees one weight set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++) r_wt[k] <= TW_ZERO;
    end else if (wt_we && !busy && (int'(wt_addr) < NW)) begin
      r_wt[wt_addr] <= wt_data;
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    localparam logic [AW-1:0] BASE = AW'(j * N_IN);
    logic [AW-1:0]           w_idx;
    logic [1:0]              w_wt;
    logic signed [ACC_W-1:0] w_res;

    assign w_idx = BASE + AW'(r_cnt);
    assign w_wt  = r_wt[w_idx];

    fc_ternary_neuron #(
      .A_W  (A_W),
      .ACC_W(ACC_W),
      .AI   (AI)
    ) u_neuron (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_beat  (w_accept),
      .i_first (w_first),
      .i_last  (w_last),
      .i_bypass(relu_bypass),
      .i_wt    (w_wt),
      .i_act   (in_data),
      .o_res   (w_res)
    );

    assign out_data[j*ACC_W +: ACC_W] = w_res;
  end

endmodule

// File: tb/tb_fc_ternary_layer.sv
// Scoreboard bench for fc_ternary_layer: two instances (ACC_W 16 and 10)
// share stimulus; a reference model of weights as -1/0/+1 integers predicts
// each frame's clamped dot products.
module tb_fc_ternary_layer;
  localparam int N_IN  = 8;
  localparam int N_OUT = 10;
  localparam int A_W   = 9;
  localparam int AW    = $clog2(N_OUT*N_IN);

  logic clk = 1'b0;
  logic rst_n, in_valid, relu_bypass, wt_we, out_ready;
  logic [A_W-1:0] in_data;
  logic [AW-1:0]  wt_addr;
  logic [1:0]     wt_data;
  logic ira, irb, busya, busyb, ova, ovb;
  logic [N_OUT*16-1:0] od16;
  logic [N_OUT*10-1:0] od10;

  always #5 clk = ~clk;

  fc_ternary_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .A_W(A_W), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ira), .in_data(in_data),
    .relu_bypass(relu_bypass), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .busy(busya), .out_valid(ova), .out_ready(out_ready), .out_data(od16));

  fc_ternary_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .A_W(A_W), .ACC_W(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irb), .in_data(in_data),
    .relu_bypass(relu_bypass), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .busy(busyb), .out_valid(ovb), .out_ready(out_ready), .out_data(od10));

  int wm [N_OUT][N_IN];
  logic [159:0] q16[$], q10[$];
  logic [159:0] e16, e10, snap;
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int code2w(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  // Expected packed vector: plain dot product, then clamp to the output range.
  function automatic logic [159:0] mkexp(input int acts[N_IN], input int w, input bit byp);
    logic [159:0] r, m;
    int s, c, hi, lo;
    r = '0;
    m = (160'd1 << w) - 160'd1;
    hi = (1 << (w-1)) - 1;
    lo = byp ? -(1 << (w-1)) : 0;
    for (int j = 0; j < N_OUT; j++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) s += wm[j][i] * acts[i];
      c = (s > hi) ? hi : ((s < lo) ? lo : s);
      r |= (160'(c) & m) << (j*w);
    end
    return r;
  endfunction

  // Monitor: compare at every output handshake.
  always @(negedge clk) begin
    if (rst_n && out_ready && ova) begin
      if (q16.size() == 0) begin
        total++; bad++; $display("FAIL res16_unexpected: got %h want none", od16);
      end else begin
        e16 = q16.pop_front();
        chk("res16", 160'(od16), e16);
      end
    end
    if (rst_n && out_ready && ovb) begin
      if (q10.size() == 0) begin
        total++; bad++; $display("FAIL res10_unexpected: got %h want none", od10);
      end else begin
        e10 = q10.pop_front();
        chk("res10", 160'(od10), e10);
      end
    end
  end

  task automatic wr(input int j, input int i, input logic [1:0] c, input bit take);
    wt_we = 1'b1; wt_addr = AW'(j*N_IN + i); wt_data = c;
    @(posedge clk); #1 wt_we = 1'b0;
    if (take) wm[j][i] = code2w(c);
  endtask

  task automatic set_neuron(input int j, input logic [1:0] c);
    for (int i = 0; i < N_IN; i++) wr(j, i, c, 1'b1);
  endtask

  task automatic beat(input int a, input bit byp);
    int n;
    in_data = A_W'(a); relu_bypass = byp; in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!ira && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL beat_timeout: got in_ready=0 want 1"); end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  // Full frame; optionally asserts a weight write alongside beat wbeat.
  task automatic frame(input int acts[N_IN], input bit byp, input int wbeat,
                       input int wj, input int wi, input logic [1:0] wc);
    q16.push_back(mkexp(acts, 16, byp));
    q10.push_back(mkexp(acts, 10, byp));
    for (int i = 0; i < N_IN; i++) begin
      if (i == wbeat) begin wt_we = 1'b1; wt_addr = AW'(wj*N_IN + wi); wt_data = wc; end
      beat(acts[i], (i == N_IN-1) ? byp : !byp);
      wt_we = 1'b0;
    end
    if (wbeat == 0) wm[wj][wi] = code2w(wc);
    chk("latency16", 160'(ova), 160'(1));
    chk("latency10", 160'(ovb), 160'(1));
  endtask

  task automatic drain();
    int n = 0;
    while ((q16.size() != 0 || q10.size() != 0) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin total++; bad++; $display("FAIL drain_timeout: got %0d pending want 0", q16.size()); end
    @(posedge clk); #1;
  endtask

  task automatic rand_acts(output int a[N_IN]);
    for (int i = 0; i < N_IN; i++) a[i] = int'($urandom_range(0, 511)) - 256;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acts[N_IN];
    rst_n = 1'b0; in_valid = 1'b0; relu_bypass = 1'b0; wt_we = 1'b0; out_ready = 1'b1;
    in_data = '0; wt_addr = '0; wt_data = '0;
    for (int j = 0; j < N_OUT; j++) for (int i = 0; i < N_IN; i++) wm[j][i] = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", 160'(ira), 160'(1));
    chk("rst_busy", 160'(busya), 160'(0));
    chk("rst_out_valid", 160'(ova), 160'(0));
    chk("rst_out_data", 160'(od16), 160'(0));

    // neuron 0 all +1, activations 1..8
    set_neuron(0, 2'b01);
    for (int i = 0; i < N_IN; i++) acts[i] = i + 1;
    frame(acts, 1'b0, -1, 0, 0, 2'b00);
    chk("busy_in_out", 160'(busya), 160'(1));
    drain();

    // neuron 1 all -1, neuron 2 reserved code
    set_neuron(1, 2'b11);
    set_neuron(2, 2'b10);
    frame(acts, 1'b0, -1, 0, 0, 2'b00); drain();
    frame(acts, 1'b1, -1, 0, 0, 2'b00); drain();

    // saturation corners
    set_neuron(1, 2'b00);
    set_neuron(2, 2'b00);
    for (int i = 0; i < N_IN; i++) acts[i] = 255;
    frame(acts, 1'b0, -1, 0, 0, 2'b00); drain();
    for (int i = 0; i < N_IN; i++) acts[i] = -256;
    frame(acts, 1'b1, -1, 0, 0, 2'b00); drain();
    frame(acts, 1'b0, -1, 0, 0, 2'b00); drain();

    // output backpressure with in_valid held high
    set_neuron(4, 2'b11);
    out_ready = 1'b0;
    rand_acts(acts);
    frame(acts, 1'b1, -1, 0, 0, 2'b00);
    snap = 160'(od16);
    in_valid = 1'b1; in_data = A_W'(77);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_data", 160'(od16), snap);
      chk("hold_in_ready", 160'(ira), 160'(0));
      chk("hold_valid", 160'(ova), 160'(1));
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    drain();
    rand_acts(acts);
    frame(acts, 1'b0, -1, 0, 0, 2'b00); drain();

    // reset mid-frame
    for (int i = 0; i < 4; i++) beat(int'($urandom_range(0, 255)), 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 160'(ova), 160'(0));
    chk("midrst_busy", 160'(busya), 160'(0));
    chk("midrst_data", 160'(od16), 160'(0));
    rst_n = 1'b1;
    for (int j = 0; j < N_OUT; j++) for (int i = 0; i < N_IN; i++) wm[j][i] = 0;
    chk("midrst_ready", 160'(ira), 160'(1));
    rand_acts(acts);
    frame(acts, 1'b1, -1, 0, 0, 2'b00); drain();
    set_neuron(0, 2'b01);
    set_neuron(5, 2'b11);
    rand_acts(acts);
    frame(acts, 1'b1, -1, 0, 0, 2'b00); drain();

    // writes while busy are dropped; idle writes land; same-cycle first beat sees old
    for (int i = 0; i < N_IN; i++) acts[i] = 10 * (i + 1);
    frame(acts, 1'b1, 3, 3, 0, 2'b01); drain();
    out_ready = 1'b0;
    frame(acts, 1'b1, -1, 0, 0, 2'b00);
    wr(3, 1, 2'b01, 1'b0);
    out_ready = 1'b1;
    drain();
    wr(3, 0, 2'b01, 1'b1);
    frame(acts, 1'b1, -1, 0, 0, 2'b00); drain();
    frame(acts, 1'b1, 0, 3, 0, 2'b11); drain();
    frame(acts, 1'b1, -1, 0, 0, 2'b00); drain();

    // randomized weights and activations
    for (int f = 0; f < 6; f++) begin
      if (f % 2 == 0)
        for (int j = 0; j < N_OUT; j++)
          for (int i = 0; i < N_IN; i++) wr(j, i, 2'($urandom_range(0, 3)), 1'b1);
      rand_acts(acts);
      frame(acts, 1'($urandom_range(0, 1)), -1, 0, 0, 2'b00);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
